axis_frame_checker: RTL and testbench
=====================================

// Module: axis_frame_checker
// PURPOSE
//  AXI4-Stream video sink/checker directly downstream of the VFP mm2s output channel.
//  Accepts the processed pixel stream, with optional programmable back-pressure.
//  Checks frame geometry using tuser (SOF) and tlast (EOL), and accumulates a per-frame checksum.
//  Reports per-frame status, so the camera-to-VFP path is checked in sim and on HW.
// PARAMETERS
//  DATA_WIDTH   16   tdata width (matches mm2s TDATA width)
//  IMG_WIDTH    400  pixels per line expected; must be >= 2
//  IMG_HEIGHT   300  lines per frame expected; must be >= 1
//  CNT_WIDTH    12   width of x/y counters; 2**CNT_WIDTH > max(IMG_WIDTH,IMG_HEIGHT)
// PORTS
//  m_axis_mm2s_aclk     in   1           single clock
//  m_axis_mm2s_aresetn  in   1           async active-low reset
//  s_axis_tvalid        in   1           beat valid
//  s_axis_tready        out  1           beat ready (back-pressure)
//  s_axis_tuser         in   1           start of frame (first pixel)
//  s_axis_tlast         in   1           end of line (last pixel of line)
//  s_axis_tdata         in   DATA_WIDTH  pixel data
//  stall_mask           in   4           bit i=1 -> tready low when phase==i
//  frame_done           out  1           1-cycle pulse: a frame ended (complete or aborted)
//  frame_ok             out  1           valid with frame_done: no errors in frame
//  err_sof              out  1           sticky/frame: tuser seen mid-frame
//  err_eol_early        out  1           sticky/frame: tlast before IMG_WIDTH pixels
//  err_eol_late         out  1           sticky/frame: no tlast at pixel IMG_WIDTH
//  frame_count          out  16          completed-or-aborted frames, wraps
//  drop_count           out  16          beats discarded while WAIT_SOF, saturates
//  checksum             out  32          sum of tdata over last reported frame
// BEHAVIOUR
//  Reset (async, aresetn=0)
//   - All outputs, counters and state are 0.
//   - FSM goes to WAIT_SOF; tready=0 while in reset.
//  Handshake
//   - phase: 2-bit free-running counter, +1 every cycle.
//   - tready = ~stall_mask[phase] (registered).
//   - accept = tvalid & tready. Only accepted beats change x/y/sum/state.
//  FSM
//   - WAIT_SOF:
//     - accept & tuser -> IN_FRAME with x=1, y=0, sum=tdata, errors cleared.
//     - accept & ~tuser -> drop_count++ (sat 16'hFFFF).
//   - IN_FRAME, accept & tuser (mid-frame SOF):
//     - Report aborted frame: frame_done, frame_ok=0, err_sof=1.
//     - Restart: x=1, y=0, sum=tdata, errors cleared next frame.
//   - IN_FRAME, accept & ~tuser:
//     - sum += tdata, zero-extended, mod 2**32.
//     - End of line when tlast or x+1==IMG_WIDTH; then x=0, y++.
//     - tlast with x+1<IMG_WIDTH -> err_eol_early.
//     - x+1==IMG_WIDTH without tlast -> err_eol_late (line still closed).
//     - End of line with y==IMG_HEIGHT-1 -> report complete frame, go WAIT_SOF.
//   - Non-tuser beat at x==0 starts the next line normally.
//  Reporting
//   - Registered outputs, 1 cycle after the ending beat is accepted:
//     - frame_done=1 for one cycle, frame_count++.
//     - checksum <= final sum.
//     - frame_ok = ~(any err).
//     - err_* hold until the next report.
//  Simultaneous events
//   - tuser & tlast on the same beat: tuser handling wins.
//     - In WAIT_SOF: err_eol_early for the new frame.
//   - Frame ending on the same cycle as a new tuser beat: cannot occur, as the end needs an accepted beat.
//  Mid-operation reset
//   - Immediate return to reset values.
//   - No frame_done for the interrupted frame.
// TESTING
//  T1: stall_mask=0, one 4x2 frame (IMG_WIDTH=4, IMG_HEIGHT=2), data 1..8, correct tuser/tlast
//      -> frame_done once, frame_ok=1, checksum=36, frame_count=1.
//  T2: stall_mask=4'b1010, same frame
//      -> tready toggles 1,0,1,0 by phase; same checksum=36; no beat lost or duplicated.
//  T3: 3 beats without tuser, then valid frame
//      -> drop_count=3, frame_ok=1.
//  T4: tlast on pixel 2 of line 0
//      -> err_eol_early=1, frame_ok=0; y advances; frame ends after next full line.
//  T5: tuser at x=2,y=1, then a clean frame
//      -> aborted report: err_sof=1, frame_ok=0.
//      -> Next report: frame_ok=1, err_*=0, frame_count=2.
//  T6: reset asserted mid-line, released, clean frame
//      -> no report for the partial frame; outputs 0 during reset; then frame_count=1, frame_ok=1.

Source files
------------

// File: rtl/axis_frame_checker.sv
// rtl/axis_frame_checker.sv - AXI4-Stream video sink: frame geometry check, checksum, per-frame status
module axis_frame_checker #(
  parameter int DATA_WIDTH = 16,
  parameter int IMG_WIDTH  = 400,
  parameter int IMG_HEIGHT = 300,
  parameter int CNT_WIDTH  = 12
) (
  input  logic                  m_axis_mm2s_aclk,
  input  logic                  m_axis_mm2s_aresetn,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tuser,
  input  logic                  s_axis_tlast,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [3:0]            stall_mask,
  output logic                  frame_done,
  output logic                  frame_ok,
  output logic                  err_sof,
  output logic                  err_eol_early,
  output logic                  err_eol_late,
  output logic [15:0]           frame_count,
  output logic [15:0]           drop_count,
  output logic [31:0]           checksum
);

  typedef enum logic {
    WAIT_SOF = 1'b0,
    IN_FRAME = 1'b1
  } state_t;

  localparam logic [CNT_WIDTH-1:0] X_LAST = CNT_WIDTH'(IMG_WIDTH - 1);
  localparam logic [CNT_WIDTH-1:0] Y_LAST = CNT_WIDTH'(IMG_HEIGHT - 1);

  state_t                 state_q, state_d;
  logic [1:0]             phase_q, phase_d;
  logic                   tready_q, tready_d;
  logic [CNT_WIDTH-1:0]   x_q, x_d;
  logic [CNT_WIDTH-1:0]   y_q, y_d;
  logic [31:0]            sum_q, sum_d;
  logic                   acc_early_q, acc_early_d;
  logic                   acc_late_q, acc_late_d;
  logic                   done_q, done_d;
  logic                   ok_q, ok_d;
  logic                   sof_q, sof_d;
  logic                   early_q, early_d;
  logic                   late_q, late_d;
  logic [15:0]            count_q, count_d;
  logic [15:0]            drop_q, drop_d;
  logic [31:0]            csum_q, csum_d;

  logic                   accept;
  logic [31:0]            pix;
  logic [31:0]            sum_n;
  logic                   line_end;
  logic                   new_early;
  logic                   new_late;
  logic                   report;
  logic                   rep_sof;
  logic                   rep_early;
  logic                   rep_late;
  logic [31:0]            rep_sum;

  assign accept = s_axis_tvalid & tready_q;
  assign pix    = 32'(s_axis_tdata);

  // Next-state: handshake phase, line/frame tracking, and the report strobe
  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q + 2'd1;
    tready_d    = ~stall_mask[phase_d];
    x_d         = x_q;
    y_d         = y_q;
    sum_d       = sum_q;
    acc_early_d = acc_early_q;
    acc_late_d  = acc_late_q;
    done_d      = 1'b0;
    ok_d        = ok_q;
    sof_d       = sof_q;
    early_d     = early_q;
    late_d      = late_q;
    count_d     = count_q;
    drop_d      = drop_q;
    csum_d      = csum_q;
    sum_n       = sum_q + pix;
    line_end    = s_axis_tlast | (x_q == X_LAST);
    new_early   = s_axis_tlast & (x_q != X_LAST);
    new_late    = ~s_axis_tlast & (x_q == X_LAST);
    report      = 1'b0;
    rep_sof     = 1'b0;
    rep_early   = 1'b0;
    rep_late    = 1'b0;
    rep_sum     = sum_q;

    case (state_q)
      WAIT_SOF: begin
        if (accept) begin
          if (s_axis_tuser) begin
            state_d     = IN_FRAME;
            x_d         = CNT_WIDTH'(1);
            y_d         = '0;
            sum_d       = pix;
            acc_early_d = s_axis_tlast;
            acc_late_d  = 1'b0;
          end else if (drop_q != 16'hFFFF) begin
            drop_d = drop_q + 16'd1;
          end
        end
      end
      IN_FRAME: begin
        if (accept) begin
          if (s_axis_tuser) begin
            // Mid-frame SOF: close the current frame as aborted and restart on this beat
            report      = 1'b1;
            rep_sof     = 1'b1;
            rep_early   = acc_early_q;
            rep_late    = acc_late_q;
            rep_sum     = sum_q;
            x_d         = CNT_WIDTH'(1);
            y_d         = '0;
            sum_d       = pix;
            acc_early_d = s_axis_tlast;
            acc_late_d  = 1'b0;
          end else begin
            sum_d       = sum_n;
            acc_early_d = acc_early_q | new_early;
            acc_late_d  = acc_late_q | new_late;
            if (line_end) begin
              x_d = '0;
              y_d = y_q + CNT_WIDTH'(1);
              if (y_q == Y_LAST) begin
                report    = 1'b1;
                rep_early = acc_early_q | new_early;
                rep_late  = acc_late_q | new_late;
                rep_sum   = sum_n;
                state_d   = WAIT_SOF;
              end
            end else begin
              x_d = x_q + CNT_WIDTH'(1);
            end
          end
        end
      end
      default: state_d = WAIT_SOF;
    endcase

    if (report) begin
      done_d  = 1'b1;
      ok_d    = ~(rep_sof | rep_early | rep_late);
      sof_d   = rep_sof;
      early_d = rep_early;
      late_d  = rep_late;
      count_d = count_q + 16'd1;
      csum_d  = rep_sum;
    end
  end

  // State and registered outputs; reset clears everything, including an in-flight frame
  always_ff @(posedge m_axis_mm2s_aclk or negedge m_axis_mm2s_aresetn) begin
    if (!m_axis_mm2s_aresetn) begin
      state_q     <= WAIT_SOF;
      phase_q     <= '0;
      tready_q    <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
      sum_q       <= '0;
      acc_early_q <= 1'b0;
      acc_late_q  <= 1'b0;
      done_q      <= 1'b0;
      ok_q        <= 1'b0;
      sof_q       <= 1'b0;
      early_q     <= 1'b0;
      late_q      <= 1'b0;
      count_q     <= '0;
      drop_q      <= '0;
      csum_q      <= '0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      tready_q    <= tready_d;
      x_q         <= x_d;
      y_q         <= y_d;
      sum_q       <= sum_d;
      acc_early_q <= acc_early_d;
      acc_late_q  <= acc_late_d;
      done_q      <= done_d;
      ok_q        <= ok_d;
      sof_q       <= sof_d;
      early_q     <= early_d;
      late_q      <= late_d;
      count_q     <= count_d;
      drop_q      <= drop_d;
      csum_q      <= csum_d;
    end
  end

  assign s_axis_tready = tready_q;
  assign frame_done    = done_q;
  assign frame_ok      = ok_q;
  assign err_sof       = sof_q;
  assign err_eol_early = early_q;
  assign err_eol_late  = late_q;
  assign frame_count   = count_q;
  assign drop_count    = drop_q;
  assign checksum      = csum_q;

endmodule

// File: tb/tb_axis_frame_checker.sv
// tb/tb_axis_frame_checker.sv - directed self-checking bench for axis_frame_checker (4x2 frames)
module tb_axis_frame_checker;

  logic        clk;
  logic        rst_n;
  logic        tvalid;
  logic        tready;
  logic        tuser;
  logic        tlast;
  logic [15:0] tdata;
  logic [3:0]  stall_mask;
  logic        frame_done;
  logic        frame_ok;
  logic        err_sof;
  logic        err_eol_early;
  logic        err_eol_late;
  logic [15:0] frame_count;
  logic [15:0] drop_count;
  logic [31:0] checksum;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  int d0;

  logic        snap_ok, snap_sof, snap_early, snap_late;
  logic [31:0] snap_sum;
  logic [15:0] snap_count;

  axis_frame_checker #(
    .DATA_WIDTH(16),
    .IMG_WIDTH (4),
    .IMG_HEIGHT(2),
    .CNT_WIDTH (12)
  ) dut (
    .m_axis_mm2s_aclk   (clk),
    .m_axis_mm2s_aresetn(rst_n),
    .s_axis_tvalid      (tvalid),
    .s_axis_tready      (tready),
    .s_axis_tuser       (tuser),
    .s_axis_tlast       (tlast),
    .s_axis_tdata       (tdata),
    .stall_mask         (stall_mask),
    .frame_done         (frame_done),
    .frame_ok           (frame_ok),
    .err_sof            (err_sof),
    .err_eol_early      (err_eol_early),
    .err_eol_late       (err_eol_late),
    .frame_count        (frame_count),
    .drop_count         (drop_count),
    .checksum           (checksum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Capture every report on the falling edge
  always @(negedge clk) begin
    if (frame_done) begin
      done_cnt   <= done_cnt + 1;
      snap_ok    <= frame_ok;
      snap_sof   <= err_sof;
      snap_early <= err_eol_early;
      snap_late  <= err_eol_late;
      snap_sum   <= checksum;
      snap_count <= frame_count;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Present one beat from a falling edge and hold it until accepted
  task automatic send(input logic [15:0] d, input logic u, input logic l);
    int n;
    tvalid = 1'b1;
    tdata  = d;
    tuser  = u;
    tlast  = l;
    n = 0;
    while (!tready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check_eq("beat_accept_timeout", 32'(n), 32'd0);
    @(negedge clk);
    tvalid = 1'b0;
    tuser  = 1'b0;
    tlast  = 1'b0;
  endtask

  task automatic send_frame(input logic [15:0] base);
    for (int i = 0; i < 8; i++)
      send(base + 16'(i), i == 0, (i % 4) == 3);
  endtask

  initial begin
    int toggles;
    logic prev;
    rst_n = 1'b0; tvalid = 1'b0; tuser = 1'b0; tlast = 1'b0;
    tdata = '0; stall_mask = 4'b0000;
    idle(3);
    check_eq("rst_tready", 32'(tready), 32'd0);
    check_eq("rst_done", 32'(frame_done), 32'd0);
    check_eq("rst_count", 32'(frame_count), 32'd0);
    check_eq("rst_drop", 32'(drop_count), 32'd0);
    check_eq("rst_checksum", checksum, 32'd0);
    check_eq("rst_errs", {29'd0, err_sof, err_eol_early, err_eol_late}, 32'd0);
    rst_n = 1'b1;
    idle(2);

    // T1: clean frame, no back-pressure
    d0 = done_cnt;
    send_frame(16'd1);
    idle(3);
    check_eq("t1_done", 32'(done_cnt - d0), 32'd1);
    check_eq("t1_ok", 32'(snap_ok), 32'd1);
    check_eq("t1_sum", snap_sum, 32'd36);
    check_eq("t1_count", 32'(snap_count), 32'd1);

    // T2: alternating stalls
    stall_mask = 4'b1010;
    idle(2);
    toggles = 0;
    prev = tready;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (tready != prev) toggles++;
      prev = tready;
    end
    check_eq("t2_tready_toggles", 32'(toggles), 32'd8);
    d0 = done_cnt;
    send_frame(16'd1);
    idle(3);
    check_eq("t2_done", 32'(done_cnt - d0), 32'd1);
    check_eq("t2_sum", snap_sum, 32'd36);
    check_eq("t2_ok", 32'(snap_ok), 32'd1);
    stall_mask = 4'b0000;
    idle(2);

    // T3: dropped beats before SOF
    send(16'd9, 1'b0, 1'b0);
    send(16'd9, 1'b0, 1'b1);
    send(16'd9, 1'b0, 1'b0);
    send_frame(16'd1);
    idle(3);
    check_eq("t3_drop", 32'(drop_count), 32'd3);
    check_eq("t3_ok", 32'(snap_ok), 32'd1);
    check_eq("t3_sum", snap_sum, 32'd36);

    // T4: early tlast on second pixel of line 0
    d0 = done_cnt;
    send(16'd1, 1'b1, 1'b0);
    send(16'd2, 1'b0, 1'b1);
    send(16'd3, 1'b0, 1'b0);
    send(16'd4, 1'b0, 1'b0);
    send(16'd5, 1'b0, 1'b0);
    send(16'd6, 1'b0, 1'b1);
    idle(3);
    check_eq("t4_done", 32'(done_cnt - d0), 32'd1);
    check_eq("t4_ok", 32'(snap_ok), 32'd0);
    check_eq("t4_early", 32'(snap_early), 32'd1);
    check_eq("t4_late", 32'(snap_late), 32'd0);
    check_eq("t4_sum", snap_sum, 32'd21);

    // T5: SOF at x=2,y=1 aborts; the SOF beat begins a clean frame
    send(16'd10, 1'b1, 1'b0);
    send(16'd20, 1'b0, 1'b0);
    send(16'd30, 1'b0, 1'b0);
    send(16'd40, 1'b0, 1'b1);
    send(16'd50, 1'b0, 1'b0);
    send(16'd60, 1'b0, 1'b0);
    d0 = done_cnt;
    send(16'd1, 1'b1, 1'b0);
    idle(3);
    check_eq("t5_abort_done", 32'(done_cnt - d0), 32'd1);
    check_eq("t5_abort_sof", 32'(snap_sof), 32'd1);
    check_eq("t5_abort_ok", 32'(snap_ok), 32'd0);
    check_eq("t5_abort_sum", snap_sum, 32'd210);
    check_eq("t5_abort_count", 32'(snap_count), 32'd5);
    for (int i = 1; i < 8; i++)
      send(16'(i + 1), 1'b0, (i % 4) == 3);
    idle(3);
    check_eq("t5_next_ok", 32'(snap_ok), 32'd1);
    check_eq("t5_next_errs", {29'd0, snap_sof, snap_early, snap_late}, 32'd0);
    check_eq("t5_next_sum", snap_sum, 32'd36);
    check_eq("t5_next_count", 32'(snap_count), 32'd6);

    // T7: tuser+tlast on SOF beat, then missing tlast at end of line 0
    send(16'd1, 1'b1, 1'b1);
    send(16'd1, 1'b0, 1'b0);
    send(16'd1, 1'b0, 1'b0);
    send(16'd1, 1'b0, 1'b0);
    send(16'd1, 1'b0, 1'b0);
    send(16'd1, 1'b0, 1'b0);
    send(16'd1, 1'b0, 1'b0);
    send(16'd1, 1'b0, 1'b1);
    idle(3);
    check_eq("t7_early", 32'(snap_early), 32'd1);
    check_eq("t7_late", 32'(snap_late), 32'd1);
    check_eq("t7_ok", 32'(snap_ok), 32'd0);
    check_eq("t7_sum", snap_sum, 32'd8);
    check_eq("t7_count", 32'(snap_count), 32'd7);

    // T6: reset mid-line
    send(16'd5, 1'b1, 1'b0);
    send(16'd6, 1'b0, 1'b0);
    d0 = done_cnt;
    rst_n = 1'b0;
    @(negedge clk);
    check_eq("t6_rst_tready", 32'(tready), 32'd0);
    check_eq("t6_rst_count", 32'(frame_count), 32'd0);
    check_eq("t6_rst_checksum", checksum, 32'd0);
    check_eq("t6_rst_drop", 32'(drop_count), 32'd0);
    check_eq("t6_rst_ok", 32'(frame_ok), 32'd0);
    idle(2);
    rst_n = 1'b1;
    idle(2);
    send_frame(16'd1);
    idle(3);
    check_eq("t6_done", 32'(done_cnt - d0), 32'd1);
    check_eq("t6_count", 32'(frame_count), 32'd1);
    check_eq("t6_ok", 32'(snap_ok), 32'd1);
    check_eq("t6_sum", snap_sum, 32'd36);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
